button_event_decoder: RTL
=========================

# button_event_decoder

Classifies the clean, synchronized level from the debouncer into single-cycle user events: press, release, short click, long press and double click. It sits directly downstream of the debouncer. Its `debounced_in` connects to the debouncer's `debouncer_out`. Its event pulses feed control logic that must not see raw levels.

## Interface

Parameters:
- `LONG_CLKS`, default 2000: hold duration in clocks, measured from the press pulse, that qualifies as a long press. Legal range ≥ 2.
- `DOUBLE_GAP_CLKS`, default 1000: maximum release-to-press gap in clocks for a second press to count as a double click. Legal range ≥ 2.
- `CNT_W`, default `$clog2(max(LONG_CLKS, DOUBLE_GAP_CLKS)+1)`: width of the shared timer. Derived; never overridden.

Ports:
- `clk` input 1: single clock. All logic is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `debounced_in` input 1: clean level, already synchronized and debounced upstream. 1 = pressed.
- `press_pulse` output 1: one-cycle pulse on each accepted press.
- `release_pulse` output 1: one-cycle pulse on each release.
- `short_click` output 1: one-cycle pulse for a single short click, confirmed after the gap expires.
- `long_press` output 1: one-cycle pulse when a hold reaches `LONG_CLKS`.
- `double_click` output 1: one-cycle pulse on release of the second short press.

## Operation

Edge detection:
- A `prev` register holds the previous sample; `rise = debounced_in & ~prev` and `fall = ~debounced_in & prev`.
- `prev` resets to 0, so an input that is already high at reset release yields `press_pulse` on the first cycle.

Timer:
- Single `CNT_W`-bit up-counter, cleared on every state change and incremented otherwise.
- Saturates at its maximum; it never wraps.

FSM states and transitions:
- `IDLE`:
  - `rise` → `press_pulse`, go to `PRESSED`.
- `PRESSED`:
  - `fall` before the timer reaches `LONG_CLKS-1` → `release_pulse`, go to `WAIT_GAP`.
  - Timer reaches `LONG_CLKS-1` while high → `long_press`, go to `LONG_HELD`.
- `LONG_HELD`:
  - `fall` → `release_pulse`, go to `IDLE`. No click event is emitted.
- `WAIT_GAP`:
  - `rise` → `press_pulse`, go to `SECOND`.
  - Otherwise, timer reaches `DOUBLE_GAP_CLKS-1` → `short_click`, go to `IDLE`.
- `SECOND`:
  - `fall` before `LONG_CLKS-1` → `release_pulse` and `double_click` in the same cycle, go to `IDLE`.
  - Reaches `LONG_CLKS-1` → `long_press`, go to `LONG_HELD`. The first click is discarded and no `short_click` is emitted.

Simultaneous events:
- A `rise` on the timeout edge in `WAIT_GAP` wins; it counts as the second press.
- `fall` and the long threshold on the same edge: `fall` wins, so the event is classified as short.

Output rules:
- All outputs are registered, and every output is 0 in reset.
- At most two outputs are high in any cycle, and only as the pairs `release_pulse`+`double_click`.

Reset:
- Reset mid-operation immediately returns the FSM to `IDLE` and clears the timer, `prev` and all outputs.
- Pending classifications are dropped.

## Timing

- Let edge E be the first rising edge sampling `debounced_in=1` after 0. `press_pulse` is high in the cycle following E (latency 1).
- The first press is at cycle P, with the input held. `long_press` is high at cycle P+`LONG_CLKS`.
- A release at cycle R with no new press gives `short_click` at R+`DOUBLE_GAP_CLKS`.
- A press accepted at R+k with 1 ≤ k ≤ `DOUBLE_GAP_CLKS` is a second press.
- `double_click` shares the cycle of the second `release_pulse`.

## Structure

- Package `button_event_pkg`:
  - FSM state enum: `IDLE`, `PRESSED`, `LONG_HELD`, `WAIT_GAP`, `SECOND`.
  - Timer-width function.
- Sub-module `edge_detector`:
  - Ports: `clk`, `rst`, `din`, `rise`, `fall`.
  - Contains the `prev` register. Reusable elsewhere.
- Top level holds the FSM, timer and output registers.

## Test plan

Bench parameters: `LONG_CLKS=20`, `DOUBLE_GAP_CLKS=10`, 10 ns clock. Each check is one-hot pulse-accurate.

- Reset with the input low, then hold low 100 cycles → all outputs stay 0.
- High for 5 cycles, then low → `press_pulse` at P, `release_pulse` at P+5, `short_click` at P+15, nothing else.
- High for 30 cycles → `long_press` at P+20, `release_pulse` at P+30, no `short_click`.
- High 5, low 4, high 5, low → two `press_pulse`, then `release_pulse` and `double_click` in the same cycle, no `short_click`.
- Gap boundary:
  - Low gap of exactly 10 cycles → second press accepted as double click.
  - Gap of 11 → `short_click`, then a fresh single-click sequence.
- Assert `rst` for 1 cycle mid-hold at P+12 → outputs 0, FSM in `IDLE`, no `long_press`. Still-high input yields `press_pulse` after release of `rst`.

Source files
------------

// File: rtl/button_event_pkg.sv
// button_event_pkg: shared FSM state type and timer sizing for button_event_decoder
package button_event_pkg;

    typedef enum logic [2:0] {IDLE, PRESSED, LONG_HELD, WAIT_GAP, SECOND} state_t;

    function automatic int timer_width(input int long_clks, input int gap_clks);
        return $clog2((long_clks > gap_clks ? long_clks : gap_clks) + 1);
    endfunction

endpackage

// File: rtl/edge_detector.sv
// edge_detector: registered previous sample plus combinational rise/fall strobes
module edge_detector (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic prev;

    always_ff @(posedge clk)
        prev <= rst ? 1'b0 : din;

    assign rise = din & ~prev;
    assign fall = ~din & prev;

endmodule

// File: rtl/button_event_decoder.sv
// button_event_decoder: turns a debounced level into press/release/click/long/double pulses
module button_event_decoder
    import button_event_pkg::*;
#(
    parameter int LONG_CLKS       = 2000,
    parameter int DOUBLE_GAP_CLKS = 1000,
    parameter int CNT_W           = timer_width(LONG_CLKS, DOUBLE_GAP_CLKS)
) (
    input  logic clk,
    input  logic rst,
    input  logic debounced_in,
    output logic press_pulse,
    output logic release_pulse,
    output logic short_click,
    output logic long_press,
    output logic double_click
);

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CLKS - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(DOUBLE_GAP_CLKS - 1);

    logic rise, fall;
    state_t state;
    logic [CNT_W-1:0] timer;

    edge_detector u_edge (
        .clk (clk),
        .rst (rst),
        .din (debounced_in),
        .rise(rise),
        .fall(fall)
    );

    // Branch order encodes priority: fall beats the long threshold, rise beats the gap timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            timer         <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_click   <= 1'b0;
            long_press    <= 1'b0;
            double_click  <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_click   <= 1'b0;
            long_press    <= 1'b0;
            double_click  <= 1'b0;
            timer         <= (timer == '1) ? timer : timer + 1'b1;
            case (state)
                IDLE: if (rise) begin
                    press_pulse <= 1'b1;
                    state       <= PRESSED;
                    timer       <= '0;
                end
                PRESSED: if (fall) begin
                    release_pulse <= 1'b1;
                    state         <= WAIT_GAP;
                    timer         <= '0;
                end else if (timer == LONG_LAST) begin
                    long_press <= 1'b1;
                    state      <= LONG_HELD;
                    timer      <= '0;
                end
                LONG_HELD: if (fall) begin
                    release_pulse <= 1'b1;
                    state         <= IDLE;
                    timer         <= '0;
                end
                WAIT_GAP: if (rise) begin
                    press_pulse <= 1'b1;
                    state       <= SECOND;
                    timer       <= '0;
                end else if (timer == GAP_LAST) begin
                    short_click <= 1'b1;
                    state       <= IDLE;
                    timer       <= '0;
                end
                SECOND: if (fall) begin
                    release_pulse <= 1'b1;
                    double_click  <= 1'b1;
                    state         <= IDLE;
                    timer         <= '0;
                end else if (timer == LONG_LAST) begin
                    long_press <= 1'b1;
                    state      <= LONG_HELD;
                    timer      <= '0;
                end
                default: begin
                    state <= IDLE;
                    timer <= '0;
                end
            endcase
        end
    end

endmodule
